temporizador_regressivo: RTL and testbench

//  BCD countdown timer HH:MM:SS, the down-counting counterpart of the clock's up-counting hour/min/sec chain.

---
 rtl/relogio_pkg.sv | 23 ++
 rtl/regressivo_60.sv | 51 +++++
 rtl/temporizador_regressivo.sv | 178 +++++++++++++++++
 tb/tb_temporizador_regressivo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/relogio_pkg.sv
// Shared BCD time-format definitions for the clock and countdown timer datapaths.
package relogio_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        FIM      = 2'd3
    } estado_t;

    localparam int W_UNI  = 4;
    localparam int W_DEZ  = 3;
    localparam int W_HDEZ = 2;

    localparam logic [W_UNI-1:0] MAX_UNIDADE   = 4'd9;
    localparam logic [W_DEZ-1:0] MAX_DEZENA_MS = 3'd5;

    // Legal minutes/seconds pair: units 0..9, tens 0..5.
    function automatic logic bcd_valido(input logic [W_UNI-1:0] u, input logic [W_DEZ-1:0] d);
        return (u <= MAX_UNIDADE) && (d <= MAX_DEZENA_MS);
    endfunction

endpackage

// File: rtl/regressivo_60.sv
// One down-counting BCD pair (00..59) for minutes or seconds, with borrow to the next pair.
module regressivo_60
    import relogio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             carga,
    input  logic [W_UNI-1:0] ld_u,
    input  logic [W_DEZ-1:0] ld_d,
    output logic [W_UNI-1:0] unidade,
    output logic [W_DEZ-1:0] dezena,
    output logic             borrow_out,
    output logic             zero
);

    logic [W_UNI-1:0] uni_q, uni_d;
    logic [W_DEZ-1:0] dez_q, dez_d;

    always_comb begin
        uni_d = uni_q;
        dez_d = dez_q;
        if (carga) begin
            uni_d = ld_u;
            dez_d = ld_d;
        end else if (dec) begin
            if (uni_q == 4'd0) begin
                uni_d = MAX_UNIDADE;
                dez_d = (dez_q == 3'd0) ? MAX_DEZENA_MS : dez_q - 3'd1;
            end else begin
                uni_d = uni_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uni_q <= '0;
            dez_q <= '0;
        end else begin
            uni_q <= uni_d;
            dez_q <= dez_d;
        end
    end

    assign unidade    = uni_q;
    assign dezena     = dez_q;
    assign zero       = (uni_q == 4'd0) && (dez_q == 3'd0);
    assign borrow_out = dec && zero;

endmodule

// File: rtl/temporizador_regressivo.sv
// BCD HH:MM:SS countdown timer driven by the shared 1 Hz tick.
// Optional build macro TIMER_AUTO_RELOAD_EN: reload the stored value at expiry and keep counting.
module temporizador_regressivo
    import relogio_pkg::*;
#(
    parameter int HORA_MAX = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              carregar,
    input  logic [W_UNI-1:0]  ld_seg_u,
    input  logic [W_DEZ-1:0]  ld_seg_d,
    input  logic [W_UNI-1:0]  ld_min_u,
    input  logic [W_DEZ-1:0]  ld_min_d,
    input  logic [W_UNI-1:0]  ld_hora_u,
    input  logic [W_HDEZ-1:0] ld_hora_d,
    input  logic              iniciar,
    input  logic              pausar,
    input  logic              reconhece,
    output logic [W_UNI-1:0]  seg_u,
    output logic [W_DEZ-1:0]  seg_d,
    output logic [W_UNI-1:0]  min_u,
    output logic [W_DEZ-1:0]  min_d,
    output logic [W_UNI-1:0]  hora_u,
    output logic [W_HDEZ-1:0] hora_d,
    output logic [1:0]        estado,
    output logic              fim,
    output logic              alarme,
    output logic              erro_carga
);

    localparam logic [5:0] HORA_MAX_B = 6'(HORA_MAX);

    estado_t state_q, state_d;
    logic    fim_q, fim_d, erro_q, erro_d;
    logic    dec_tick, carga_cnt, usa_reload;

    logic [W_UNI-1:0]  rl_seg_u_q, rl_min_u_q, rl_hora_u_q;
    logic [W_DEZ-1:0]  rl_seg_d_q, rl_min_d_q;
    logic [W_HDEZ-1:0] rl_hora_d_q;

    logic [W_UNI-1:0]  hora_u_q, hora_u_d;
    logic [W_HDEZ-1:0] hora_d_q, hora_d_d;

    logic [W_UNI-1:0]  cs_u, cm_u, ch_u;
    logic [W_DEZ-1:0]  cs_d, cm_d;
    logic [W_HDEZ-1:0] ch_d;

    logic       seg_zero, seg_borrow, min_zero, min_borrow;
    logic [5:0] hora_val;
    logic       carga_valida, cont_zero, cont_um;

    assign hora_val     = 6'(ld_hora_d) * 6'd10 + 6'(ld_hora_u);
    assign carga_valida = bcd_valido(ld_seg_u, ld_seg_d) && bcd_valido(ld_min_u, ld_min_d) &&
                          (ld_hora_u <= MAX_UNIDADE) && (hora_val <= HORA_MAX_B);

    assign cont_zero = seg_zero && min_zero && (hora_u_q == 4'd0) && (hora_d_q == 2'd0);
    assign cont_um   = (seg_u == 4'd1) && (seg_d == 3'd0) && min_zero &&
                       (hora_u_q == 4'd0) && (hora_d_q == 2'd0);

    always_comb begin
        state_d    = state_q;
        dec_tick   = 1'b0;
        carga_cnt  = 1'b0;
        usa_reload = 1'b0;
        fim_d      = 1'b0;
        erro_d     = 1'b0;
        if (carregar) begin
            if (carga_valida) begin
                carga_cnt = 1'b1;
                state_d   = OCIOSO;
            end else begin
                erro_d = 1'b1;
            end
        end else begin
            case (state_q)
                OCIOSO, PAUSADO: begin
                    if (iniciar && !cont_zero) state_d = CONTANDO;
                end
                CONTANDO: begin
                    if (pausar) begin
                        state_d = PAUSADO;
                    end else if (tick_1hz) begin
                        fim_d = cont_um;
                        if (cont_um) begin
`ifdef TIMER_AUTO_RELOAD_EN
                            carga_cnt  = 1'b1;
                            usa_reload = 1'b1;
`else
                            dec_tick = 1'b1;
                            state_d  = FIM;
`endif
                        end else begin
                            dec_tick = 1'b1;
                        end
                    end
                end
                FIM: begin
                    if (reconhece) state_d = OCIOSO;
                end
                default: state_d = OCIOSO;
            endcase
        end
    end

    // Count load source: external load value, or the captured reload value at auto-reload expiry.
    assign cs_u = usa_reload ? rl_seg_u_q  : ld_seg_u;
    assign cs_d = usa_reload ? rl_seg_d_q  : ld_seg_d;
    assign cm_u = usa_reload ? rl_min_u_q  : ld_min_u;
    assign cm_d = usa_reload ? rl_min_d_q  : ld_min_d;
    assign ch_u = usa_reload ? rl_hora_u_q : ld_hora_u;
    assign ch_d = usa_reload ? rl_hora_d_q : ld_hora_d;

    regressivo_60 u_seg (
        .clk(clk), .rst(rst), .dec(dec_tick), .carga(carga_cnt), .ld_u(cs_u), .ld_d(cs_d),
        .unidade(seg_u), .dezena(seg_d), .borrow_out(seg_borrow), .zero(seg_zero)
    );

    regressivo_60 u_min (
        .clk(clk), .rst(rst), .dec(seg_borrow), .carga(carga_cnt), .ld_u(cm_u), .ld_d(cm_d),
        .unidade(min_u), .dezena(min_d), .borrow_out(min_borrow), .zero(min_zero)
    );

    always_comb begin
        hora_u_d = hora_u_q;
        hora_d_d = hora_d_q;
        if (carga_cnt) begin
            hora_u_d = ch_u;
            hora_d_d = ch_d;
        end else if (min_borrow) begin
            if (hora_u_q == 4'd0) begin
                hora_u_d = MAX_UNIDADE;
                hora_d_d = hora_d_q - 2'd1;
            end else begin
                hora_u_d = hora_u_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OCIOSO;
            fim_q       <= 1'b0;
            erro_q      <= 1'b0;
            hora_u_q    <= '0;
            hora_d_q    <= '0;
            rl_seg_u_q  <= '0;
            rl_seg_d_q  <= '0;
            rl_min_u_q  <= '0;
            rl_min_d_q  <= '0;
            rl_hora_u_q <= '0;
            rl_hora_d_q <= '0;
        end else begin
            state_q  <= state_d;
            fim_q    <= fim_d;
            erro_q   <= erro_d;
            hora_u_q <= hora_u_d;
            hora_d_q <= hora_d_d;
            if (carregar && carga_valida) begin
                rl_seg_u_q  <= ld_seg_u;
                rl_seg_d_q  <= ld_seg_d;
                rl_min_u_q  <= ld_min_u;
                rl_min_d_q  <= ld_min_d;
                rl_hora_u_q <= ld_hora_u;
                rl_hora_d_q <= ld_hora_d;
            end
        end
    end

    assign hora_u     = hora_u_q;
    assign hora_d     = hora_d_q;
    assign estado     = state_q;
    assign fim        = fim_q;
    assign alarme     = (state_q == FIM);
    assign erro_carga = erro_q;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Scoreboard bench for temporizador_regressivo: a seconds-based reference model predicts every cycle.
module tb_temporizador_regressivo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0, carregar = 1'b0, iniciar = 1'b0, pausar = 1'b0, reconhece = 1'b0;
    logic [3:0] ld_seg_u = '0, ld_min_u = '0, ld_hora_u = '0;
    logic [2:0] ld_seg_d = '0, ld_min_d = '0;
    logic [1:0] ld_hora_d = '0;
    logic [3:0] seg_u, min_u, hora_u;
    logic [2:0] seg_d, min_d;
    logic [1:0] hora_d;
    logic [1:0] estado;
    logic       fim, alarme, erro_carga;

    temporizador_regressivo #(.HORA_MAX(23)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .carregar(carregar),
        .ld_seg_u(ld_seg_u), .ld_seg_d(ld_seg_d), .ld_min_u(ld_min_u), .ld_min_d(ld_min_d),
        .ld_hora_u(ld_hora_u), .ld_hora_d(ld_hora_d),
        .iniciar(iniciar), .pausar(pausar), .reconhece(reconhece),
        .seg_u(seg_u), .seg_d(seg_d), .min_u(min_u), .min_d(min_d), .hora_u(hora_u), .hora_d(hora_d),
        .estado(estado), .fim(fim), .alarme(alarme), .erro_carga(erro_carga)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] digitos;
        logic [1:0]  estado;
        logic        fim;
        logic        alarme;
        logic        erro;
    } esperado_t;

    esperado_t fila[$];

    int n_ok = 0;
    int n_total = 0;

    int m_secs = 0;
    int m_reload = 0;
    int m_state = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        else n_ok++;
    endtask

    function automatic logic [23:0] para_bcd(input int s);
        int hh, mm, ss;
        hh = s / 3600;
        mm = (s / 60) % 60;
        ss = s % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [23:0] digitos_dut();
        return {2'b0, hora_d, hora_u, 1'b0, min_d, min_u, 1'b0, seg_d, seg_u};
    endfunction

    task automatic ciclo(input bit c, input bit r, input bit p, input bit i, input bit t);
        esperado_t e, got;
        bit valido;
        int hv;
        @(negedge clk);
        carregar = c; reconhece = r; pausar = p; iniciar = i; tick_1hz = t;
        e.fim = 1'b0;
        e.erro = 1'b0;
        hv = int'(ld_hora_d) * 10 + int'(ld_hora_u);
        valido = (ld_seg_u <= 9) && (ld_seg_d <= 5) && (ld_min_u <= 9) && (ld_min_d <= 5) &&
                 (ld_hora_u <= 9) && (hv <= 23);
        if (c) begin
            if (valido) begin
                m_secs = hv * 3600 + (int'(ld_min_d) * 10 + int'(ld_min_u)) * 60 +
                         int'(ld_seg_d) * 10 + int'(ld_seg_u);
                m_reload = m_secs;
                m_state = 0;
            end else begin
                e.erro = 1'b1;
            end
        end else if ((m_state == 0 || m_state == 2) && i) begin
            if (m_secs != 0) m_state = 1;
        end else if (m_state == 1 && p) begin
            m_state = 2;
        end else if (m_state == 1 && t) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                e.fim = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                m_secs = m_reload;
`else
                m_state = 3;
`endif
            end
        end else if (m_state == 3 && r) begin
            m_state = 0;
        end
        e.digitos = para_bcd(m_secs);
        e.estado = 2'(m_state);
        e.alarme = (m_state == 3);
        fila.push_back(e);
        @(posedge clk);
        #1;
        got = fila.pop_front();
        verifica("digitos", 32'(digitos_dut()), 32'(got.digitos));
        verifica("estado", 32'(estado), 32'(got.estado));
        verifica("fim", 32'(fim), 32'(got.fim));
        verifica("alarme", 32'(alarme), 32'(got.alarme));
        verifica("erro_carga", 32'(erro_carga), 32'(got.erro));
    endtask

    task automatic carga(input int hd, input int hu, input int md, input int mu, input int sd, input int su);
        ld_hora_d = 2'(hd); ld_hora_u = 4'(hu);
        ld_min_d = 3'(md); ld_min_u = 4'(mu);
        ld_seg_d = 3'(sd); ld_seg_u = 4'(su);
        ciclo(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) ciclo(0, 0, 0, 0, 1);
    endtask

    initial begin
        #12;
        verifica("reset_digitos", 32'(digitos_dut()), 32'h0);
        verifica("reset_estado", 32'(estado), 32'd0);
        verifica("reset_saidas", 32'({fim, alarme, erro_carga}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // expiry from 00:00:03 then acknowledge
        carga(0, 0, 0, 0, 0, 3);
        ciclo(0, 0, 0, 1, 0);
        ticks(3);
        ciclo(0, 0, 0, 0, 1);
        ciclo(0, 0, 0, 1, 0);
        ciclo(0, 1, 0, 0, 0);
        ciclo(0, 0, 0, 1, 0);

        // borrows through minutes and hours
        carga(0, 1, 0, 0, 0, 0);
        ciclo(0, 0, 0, 1, 0);
        ticks(1);
        carga(1, 0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 1, 0);
        ticks(2);
        carga(2, 3, 5, 9, 5, 9);
        ciclo(0, 0, 0, 1, 0);
        ticks(2);

        // pause drops a same-cycle tick
        carga(0, 0, 0, 5, 1, 1);
        ciclo(0, 0, 0, 1, 0);
        ticks(1);
        ciclo(0, 0, 1, 0, 1);
        ticks(2);
        ciclo(0, 0, 0, 1, 0);
        ticks(1);

        // rejected loads while counting leave everything untouched
        carga(2, 4, 0, 0, 0, 0);
        ticks(1);
        carga(0, 0, 6, 0, 0, 0);
        carga(0, 0, 0, 0, 0, 10);
        carga(0, 0, 0, 10, 0, 0);
        ticks(1);

        // zero count cannot be started
        carga(0, 0, 0, 0, 0, 0);
        ciclo(0, 0, 0, 1, 1);
        ticks(1);

        // expiry/reload from 00:00:02
        carga(0, 0, 0, 0, 0, 2);
        ciclo(0, 0, 0, 1, 0);
        ticks(5);
        ciclo(0, 0, 0, 0, 0);

        // random command mix on short counts
        for (int k = 0; k < 150; k++) begin
            bit c, r, p, i, t;
            c = ($urandom_range(0, 19) == 0);
            if (c) begin
                ld_hora_d = 2'd0; ld_hora_u = 4'd0; ld_min_d = 3'd0;
                ld_min_u = 4'($urandom_range(0, 1));
                ld_seg_d = 3'($urandom_range(0, 6));
                ld_seg_u = 4'($urandom_range(0, 11));
            end
            r = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 11) == 0);
            i = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 1) == 0);
            ciclo(c, r, p, i, t);
        end

        // asynchronous reset mid-count at 00:30:17
        carga(0, 0, 3, 0, 1, 8);
        ciclo(0, 0, 0, 1, 0);
        ticks(1);
        @(negedge clk);
        tick_1hz = 1'b1;
        #2 rst = 1'b0;
        #1;
        verifica("areset_digitos", 32'(digitos_dut()), 32'h0);
        verifica("areset_estado", 32'(estado), 32'd0);
        @(posedge clk);
        #1;
        verifica("areset_fim", 32'(fim), 32'd0);
        verifica("areset_alarme", 32'(alarme), 32'd0);
        @(negedge clk);
        tick_1hz = 1'b0;
        rst = 1'b1;
        m_secs = 0; m_reload = 0; m_state = 0;
        ciclo(0, 0, 0, 1, 1);
        carga(0, 0, 0, 0, 0, 1);
        ciclo(0, 0, 0, 1, 0);
        ticks(2);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
